// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared state encoding and ROM word layout for the IR code player
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_END   = 3'd5
    } state_e;

    // Flag bits sit directly above the DUR_W-bit payload; these are offsets from DUR_W.
    localparam int EOC_BIT = 0;
    localparam int EOT_BIT = 1;

    function automatic int rom_word_w(input int dur_w);
        return dur_w + 2;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - square-wave carrier with programmable half-period
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   half_period_i  clocks per carrier half-cycle (must be >= 1)
//   restart_i      hold counter at zero with phase high
//   enable_i       advance the carrier
//   phase_o        current carrier phase
module ir_carrier_gen #(
    parameter int CDIV_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CDIV_W-1:0] half_period_i,
    input  logic              restart_i,
    input  logic              enable_i,
    output logic              phase_o
);

    logic [CDIV_W-1:0] cnt_q;
    logic              phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (enable_i) begin
            if (cnt_q == half_period_i - CDIV_W'(1)) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + CDIV_W'(1);
            end
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/ir_code_player.sv
// rtl/ir_code_player.sv - ROM-driven IR mark/space sequencer with per-code carrier
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         level; a rising edge starts playback from word 0
//   abort         stops playback; done pulses on the following cycle
//   rom_addr      code ROM address
//   rom_data      ROM word {eot, eoc, payload}, valid one cycle after rom_addr changes
//   ir_led        carrier-modulated IR output
//   activity_led  mirrors busy
//   busy          high outside IDLE
//   done          one-cycle pulse when playback ends
// Build option: IR_LOOP_EN - replay the table while start stays high.
module ir_code_player
    import ir_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DUR_W     = 12,
    parameter int CDIV_W    = 10,
    parameter int TICK_DIV  = 10,
    parameter int GAP_TICKS = 25
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [rom_word_w(DUR_W)-1:0] rom_data,
    output logic                         ir_led,
    output logic                         activity_led,
    output logic                         busy,
    output logic                         done
);

    localparam int                TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_TICKS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_q;
    logic              data_ok_q;
    logic [CDIV_W-1:0] h_q;
    logic              mark_q, eoc_q, eot_q;
    logic [DUR_W-1:0]  left_q;
    logic [TW-1:0]     tick_q;
    logic              ir_led_q, activity_q, busy_q, done_q;
    logic              phase;

    logic [DUR_W-1:0]  payload;
    logic [CDIV_W-1:0] hdr_h;
    logic              word_eoc, word_eot;
    logic              start_rise, tick_wrap, expire, loop_restart;

    assign payload    = rom_data[DUR_W-1:0];
    assign hdr_h      = rom_data[CDIV_W-1:0];
    assign word_eoc   = rom_data[DUR_W+EOC_BIT];
    assign word_eot   = rom_data[DUR_W+EOT_BIT];
    assign start_rise = start & ~start_q;
    assign tick_wrap  = (tick_q == TICK_LAST);
    // A zero load expires on the first cycle, which is how dur=0 elements are skipped.
    assign expire     = (left_q == '0) || (tick_wrap && (left_q == DUR_W'(1)));

`ifdef IR_LOOP_EN
    assign loop_restart = start;
`else
    assign loop_restart = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise && !abort) begin
                    state_d = ST_HDR;
                    addr_d  = '0;
                end
            end
            ST_HDR, ST_FETCH: begin
                // data_ok_q marks the second cycle, when rom_data reflects rom_addr.
                if (data_ok_q) begin
                    state_d = (state_q == ST_HDR) ? ST_FETCH : ST_PLAY;
                    if (addr_q != ADDR_LAST) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (expire) begin
                    if (eot_q) begin
                        if (loop_restart) begin
                            state_d = ST_HDR;
                            addr_d  = '0;
                        end else begin
                            state_d = ST_END;
                        end
                    end else if (eoc_q) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_GAP: begin
                if (expire) begin
                    state_d = ST_HDR;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
        if (abort && (state_q != ST_IDLE) && (state_q != ST_END)) begin
            state_d = ST_END;
            addr_d  = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            start_q    <= 1'b0;
            data_ok_q  <= 1'b0;
            h_q        <= CDIV_W'(1);
            mark_q     <= 1'b1;
            eoc_q      <= 1'b0;
            eot_q      <= 1'b0;
            left_q     <= '0;
            tick_q     <= '0;
            ir_led_q   <= 1'b0;
            activity_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            start_q   <= start;
            data_ok_q <= ((state_q == ST_HDR) || (state_q == ST_FETCH))
                         && (state_d == state_q) && !data_ok_q;

            if ((state_q == ST_HDR) && data_ok_q) begin
                h_q <= (hdr_h == '0) ? CDIV_W'(1) : hdr_h;
            end

            if (state_d == ST_HDR) begin
                mark_q <= 1'b1;
            end else if ((state_q == ST_PLAY) && (state_d == ST_FETCH)) begin
                mark_q <= ~mark_q;
            end

            // One tick/duration counter serves both PLAY and GAP.
            if ((state_q == ST_FETCH) && data_ok_q) begin
                left_q <= payload;
                tick_q <= '0;
                eoc_q  <= word_eoc;
                eot_q  <= word_eot | (addr_q == ADDR_LAST);
            end else if ((state_q == ST_PLAY) && (state_d == ST_GAP)) begin
                left_q <= GAP_LOAD;
                tick_q <= '0;
            end else if ((state_q == ST_PLAY) || (state_q == ST_GAP)) begin
                if (tick_wrap) begin
                    tick_q <= '0;
                    if (left_q != '0) begin
                        left_q <= left_q - DUR_W'(1);
                    end
                end else begin
                    tick_q <= tick_q + TW'(1);
                end
            end

            ir_led_q   <= !abort && (state_q == ST_PLAY) && mark_q && phase && (left_q != '0);
            activity_q <= (state_d != ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_END);
        end
    end

    ir_carrier_gen #(
        .CDIV_W(CDIV_W)
    ) u_carrier (
        .clk          (clk),
        .rst_n        (rst_n),
        .half_period_i(h_q),
        .restart_i    (state_q != ST_PLAY),
        .enable_i     (state_q == ST_PLAY),
        .phase_o      (phase)
    );

    assign rom_addr     = addr_q;
    assign ir_led       = ir_led_q;
    assign activity_led = activity_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ir_code_player.sv
// tb/tb_ir_code_player.sv - directed self-checking bench for ir_code_player
module tb_ir_code_player;

    localparam int ADDR_W    = 4;
    localparam int DUR_W     = 12;
    localparam int CDIV_W    = 10;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 2;
    localparam int WW        = DUR_W + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [WW-1:0]     rom_data = '0;
    logic              ir_led, activity_led, busy, done;

    logic [WW-1:0]     mem [2**ADDR_W];
    int                total = 0;
    int                bad = 0;
    logic [63:0]       cap_led, cap_done, cap_busy;
    logic              seen_led;

    ir_code_player #(
        .ADDR_W(ADDR_W), .DUR_W(DUR_W), .CDIV_W(CDIV_W),
        .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ir_led(ir_led), .activity_led(activity_led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0b expected=%0b", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] word(input logic eot, input logic eoc, input int pl);
        return {eot, eoc, DUR_W'(pl)};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({ir_led, activity_led, busy, done, rom_addr});
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_led(input string tag);
        int k = 0;
        while (!ir_led && k < 80) begin
            step();
            k++;
        end
        check(tag, 64'(ir_led), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (!done && k < limit) begin
            seen_led |= ir_led;
            step();
            k++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    // Sample n cycles starting at the current one; first sample ends up in the MSB.
    task automatic capture(input int n);
        cap_led  = '0;
        cap_done = '0;
        cap_busy = '0;
        for (int i = 0; i < n; i++) begin
            cap_led  = {cap_led[62:0], ir_led};
            cap_done = {cap_done[62:0], done};
            cap_busy = {cap_busy[62:0], busy};
            step();
        end
    endtask

    task automatic run_trace(input string tag, input int n, input logic [63:0] e_led,
                             input logic [63:0] e_done, input logic [63:0] e_busy);
        pulse_start();
        wait_led({tag, "_led_rise"});
        capture(n);
        check({tag, "_led"}, cap_led, e_led);
        check({tag, "_done"}, cap_done, e_done);
        check({tag, "_busy"}, cap_busy, e_busy);
        check({tag, "_addr"}, 64'(rom_addr), 64'd0);
    endtask

    task automatic load_single();
        clear_rom();
        mem[0] = word(0, 0, 2);
        mem[1] = word(0, 0, 3);
        mem[2] = word(1, 1, 2);
    endtask

    initial begin
        clear_rom();
        seen_led = 1'b0;
        step();
        step();
        check("reset_outs", outs(), 64'd0);
        rst_n = 1'b1;
        step();

        // Single code: H=2, mark 3 ticks, space 2 ticks.
        load_single();
        run_trace("single", 23, 64'b110011001100_00000000000, 64'd2, 64'h7F_FFFE);

        // Two codes separated by the gap; B uses H=3.
        clear_rom();
        mem[0] = word(0, 0, 2);
        mem[1] = word(0, 0, 1);
        mem[2] = word(0, 1, 1);
        mem[3] = word(0, 0, 3);
        mem[4] = word(0, 0, 2);
        mem[5] = word(1, 1, 1);
        run_trace("two_codes", 37, 64'b1100_000000000000000000_11100011_0000000,
                  64'd2, 64'h1F_FFFF_FFFE);

        // H=0 header (acts as 1) and a zero-duration mark in the middle.
        clear_rom();
        mem[0] = word(0, 0, 0);
        mem[1] = word(0, 0, 1);
        mem[2] = word(0, 0, 1);
        mem[3] = word(0, 0, 0);
        mem[4] = word(0, 0, 1);
        mem[5] = word(1, 1, 1);
        run_trace("zero_mark", 26, 64'b1010_00000000000000000_1010_0, 64'd2, 64'h3FF_FFFE);

        // Abort in the middle of a lit carrier half-cycle, then replay.
        load_single();
        pulse_start();
        wait_led("abort_led_rise");
        for (int i = 0; i < 4; i++) step();
        check("abort_pre_led", 64'(ir_led), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_led_off", 64'(ir_led), 64'd0);
        check("abort_done", 64'(done), 64'd1);
        step();
        check("abort_idle", 64'({busy, done, rom_addr}), 64'd0);
        run_trace("replay", 23, 64'b110011001100_00000000000, 64'd2, 64'h7F_FFFE);

        // Start held high through the end of the table.
        start = 1'b1;
        step();
        wait_led("held_led_rise");
`ifdef IR_LOOP_EN
        capture(30);
        check("held_led", cap_led, 64'b110011001100_00000000000000_1100);
        check("held_done", cap_done, 64'd0);
        check("held_busy", cap_busy, 64'h3FFF_FFFF);
        start = 1'b0;
        wait_done("held_final_done", 100);
        wait_idle("held_idle");
`else
        capture(23);
        check("held_led", cap_led, 64'b110011001100_00000000000);
        check("held_done", cap_done, 64'd2);
        check("held_busy", cap_busy, 64'h7F_FFFE);
        capture(20);
        check("held_no_restart", cap_busy, 64'd0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        wait_led("held_rearm");
        start = 1'b0;
        wait_idle("held_idle");
`endif
        step();

        // Abort wins over a simultaneous start edge in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        capture(10);
        check("abort_start_idle", cap_busy, 64'd0);

        // Asynchronous reset while a mark is playing.
        pulse_start();
        wait_led("rst_led_rise");
        #2 rst_n = 1'b0;
        #1 check("rst_async_outs", outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table with no end markers runs to the last address and stops there.
        clear_rom();
        seen_led = 1'b0;
        pulse_start();
        wait_done("full_done", 300);
        check("full_last_addr", 64'(rom_addr), 64'(2**ADDR_W - 1));
        check("full_no_led", 64'(seen_led), 64'd0);
        step();
        check("full_idle", 64'({busy, rom_addr}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_code_player.md
Name: ir_code_player

Overview:
- Parametrised IR code sequencer for the TV-B-Gone top level; the next generation after the single-button, single-LED stub.
- Fetches a mark/space table from an external code ROM through a synchronous read port.
- Modulates marks with a per-code carrier and inserts fixed gaps between codes.
- Drives the IR LED, an activity LED, busy and done.

Parameters:
- ADDR_W, 8, code ROM address width (depth 2^ADDR_W words)
- DUR_W, 12, duration field width in ticks
- CDIV_W, 10, carrier half-period field width in clocks
- TICK_DIV, 10, clocks per duration tick (>=1)
- GAP_TICKS, 25, ticks of silence between codes

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous level; rising edge starts playback
- abort  in  1  synchronous; stops playback
- rom_addr  out  ADDR_W  code ROM address
- rom_data  in  DUR_W+2  ROM word; valid the cycle after rom_addr changes
- ir_led  out  1  modulated IR output
- activity_led  out  1  high while busy
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when playback ends, normally or via abort

Behaviour:
- Reset: all outputs 0, state IDLE, rom_addr 0. Reset is async assert and sync-released by the top level.
- ROM word format: bit DUR_W+1 = eot (end of table); bit DUR_W = eoc (end of code); low DUR_W bits = payload.
- Header word: the first word of each code. Payload[CDIV_W-1:0] is the carrier half-period H; H=0 is treated as 1. Header eoc and eot are ignored.
- Following words alternate mark, space, mark, ..., starting with mark. Payload is the duration in ticks.
- States and transitions:
  - IDLE: start rising edge -> HDR; rom_addr <= 0.
  - HDR: wait 1 cycle for data, latch H -> FETCH; rom_addr++.
  - FETCH: wait 1 cycle for data, latch the word -> PLAY; rom_addr++.
  - PLAY: run for dur*TICK_DIV clocks, with the tick prescaler restarted at PLAY entry. At expiry:
    - eoc=0 -> FETCH, mark/space phase toggles.
    - eoc=1 and eot=0 -> GAP.
    - eot=1 -> END.
  - GAP: ir_led 0 for GAP_TICKS*TICK_DIV clocks -> HDR; phase resets to mark.
  - END: done pulse, rom_addr <= 0 -> IDLE.
- Carrier: the counter restarts at each mark PLAY entry with phase high. The phase toggles every H clocks. ir_led = (state==PLAY) & mark & phase, registered with 1-cycle latency from state.
- dur=0: element skipped. PLAY lasts 1 cycle with ir_led 0, then follows the normal eoc/eot exit.
- rom_addr reaching 2^ADDR_W-1 with eot=0: that word is treated as eot=1. The address never wraps mid-table.
- start while busy: ignored. Edge detection uses the previous-cycle sample of start, which updates in all states.
- abort (any busy state): next cycle ir_led=0 and done pulses. The cycle after that the block is in IDLE with rom_addr 0.
- abort and start in the same cycle from IDLE: abort wins and nothing starts.
- abort in IDLE: no effect.
- activity_led = busy, registered.

Optional Feature:
- IR_LOOP_EN defined: at END, if start is still high, skip the done pulse and go straight to HDR at address 0, repeating the table until start falls. done pulses at the first END reached with start low.
- Not defined: a single pass per start edge.

Decomposition:
- Package ir_pkg holds:
  - state enum (IDLE, HDR, FETCH, PLAY, GAP, END)
  - ROM word field position localparams (EOT_BIT, EOC_BIT)
  - helper for the ROM word width
- Sub-module ir_carrier_gen (H input, restart, enable -> phase) is natural.
- The tick prescaler and duration counter stay inline.

Test Plan (TICK_DIV=4, GAP_TICKS=2, behavioural ROM with 1-cycle latency):
- ROM {hdr H=2, mark 3, space 2 eoc+eot}:
  - start pulse -> ir_led pattern 1100 repeated over 12 clocks, then 8 clocks low.
  - done pulses exactly 1 cycle later; busy deasserts next cycle.
- Two codes: code A eoc at word 2, code B eot:
  - ir_led low for exactly 8 clocks of GAP between codes.
  - B's carrier uses B's H (e.g. 3 -> 111000).
- Zero-duration mark in the table -> 1-cycle PLAY with ir_led 0; the following space timing is unchanged.
- abort asserted mid-mark -> ir_led 0 next cycle, done pulse, IDLE with rom_addr 0. A new start edge replays from word 0.
- start held high through END:
  - Without IR_LOOP_EN: single pass, done pulses, and no restart until start falls and rises again.
  - With IR_LOOP_EN: the table replays and done pulses only after start drops.
- Async reset asserted mid-PLAY -> all outputs 0 immediately.
- ROM filled with eoc=0/eot=0 words up to the last address -> playback terminates at address 2^ADDR_W-1 with a done pulse.
